// File: rtl/sram_pkg.sv
// sram_pkg: shared types and sizing for the SRAM controller slice.
// FSM encoding, array geometry and wait-counter width.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_DONE
  } sram_state_t;

  localparam int SRAM_WORDS  = 2048;
  localparam int SRAM_LANES  = 4;
  localparam int SRAM_WCNT_W = 4;

endpackage

// File: rtl/sram_mem.sv
// sram_mem: four byte-lane arrays with per-lane write enables.
// Single access port; read data is registered and held between reads.
module sram_mem
  import sram_pkg::*;
#(
  parameter int IDX_W  = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              acc_en_i,
  input  logic              rd_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [3:0]        be_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  for (genvar l = 0; l < SRAM_LANES; l++) begin : g_lane
    logic [7:0] mem_q [SRAM_WORDS];
    logic [7:0] rd_q;
    logic [7:0] rd_d;
    logic       we;

    assign we = acc_en_i & ~rd_i & be_i[l];

    // Lane array: not reset, written only on an enabled write access.
    always_ff @(posedge clk_i) begin
      if (we) mem_q[idx_i] <= din_i[8*l +: 8];
    end

    // Read byte is refreshed only on a read access, so it holds otherwise.
    always_comb begin
      rd_d = rd_q;
      if (acc_en_i && rd_i) rd_d = mem_q[idx_i];
    end

    // Registered read byte with reset to zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rd_q <= '0;
      else       rd_q <= rd_d;
    end

    assign dout_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: request latch, wait-state counter and handshake FSM
// in front of a 2048 x 32 byte-enabled memory.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              hclk_i,
  input  logic              hreset_i,
  input  logic              sram_cen,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_wen,
  input  logic [DATA_W-1:0] sram_din,
  input  logic [3:0]        sram_be,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_ack,
  output logic              sram_busy
);

  localparam int IDX_W = ADDR_W - 2;

  sram_state_t            state_q, state_d;
  logic [SRAM_WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   wen_q, wen_d;
  logic [3:0]             be_q, be_d;
  logic [DATA_W-1:0]      din_q, din_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic                   acc_en;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^sram_addr[1:0];

  // Access happens on the WAIT edge where the counter has run out.
  assign acc_en = (state_q == ST_WAIT) && (wait_cnt_q == '0);

  // Next-state, request latch and registered handshake outputs.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    wen_d      = wen_q;
    be_d       = be_q;
    din_d      = din_q;
    ack_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!sram_cen) begin
          idx_d      = sram_addr[ADDR_W-1:2];
          wen_d      = sram_wen;
          be_d       = sram_be;
          din_d      = sram_din;
          wait_cnt_d = SRAM_WCNT_W'(WAIT_STATES);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end else begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_DONE;
      ST_DONE: if (sram_cen) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Controller state and output registers.
  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      wen_q      <= 1'b0;
      be_q       <= '0;
      din_q      <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      wen_q      <= wen_d;
      be_q       <= be_d;
      din_q      <= din_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  sram_mem #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i    (hclk_i),
    .rst_i    (hreset_i),
    .acc_en_i (acc_en),
    .rd_i     (wen_q),
    .idx_i    (idx_q),
    .be_i     (be_q),
    .din_i    (din_q),
    .dout_o   (sram_dout)
  );

  assign sram_ack  = ack_q;
  assign sram_busy = busy_q;

endmodule
